// File: rtl/pe_cube_pkg.sv
// Shared definitions for the pe_cube result path.
// Holds the result byte width, the ceil-divide helper and the bank state type.
package pe_cube_pkg;

    localparam int RES_W = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/pe_result_bank.sv
// One ping-pong bank of the result collector: byte array, capture mask,
// full flag, capture/duplicate detection and a word-select read port.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   wr_sel         this bank is the current write bank
//   flush          close a partially filled frame
//   free           last word drained: clear full, zero the bytes
//   result         per-lane bytes, lane k at [8k+7:8k]
//   result_valid   per-lane capture strobes
//   rd_word        word index for the read port
//   full           bank holds a closed frame
//   close          frame closes at this edge
//   dup            an already-captured lane was valid again
//   state          EMPTY / FILLING / FULL
//   rd_data        packed word, lowest lane in the LSB byte
module pe_result_bank
    import pe_cube_pkg::*;
#(
    parameter int LANE_NUM  = 27,
    parameter int OUT_BYTES = 4,
    parameter int WORD_NUM  = 7,
    parameter int WCNT_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_sel,
    input  logic                        flush,
    input  logic                        free,
    input  logic [RES_W*LANE_NUM-1:0]   result,
    input  logic [LANE_NUM-1:0]         result_valid,
    input  logic [WCNT_W-1:0]           rd_word,
    output logic                        full,
    output logic                        close,
    output logic                        dup,
    output bank_state_e                 state,
    output logic [RES_W*OUT_BYTES-1:0]  rd_data
);

    localparam int PAD_N = WORD_NUM * OUT_BYTES;

    logic [LANE_NUM-1:0][RES_W-1:0]          mem;
    logic [LANE_NUM-1:0]                     mask;
    logic [LANE_NUM-1:0]                     cap;
    logic [LANE_NUM-1:0]                     nxt_mask;
    logic                                    open_w;
    logic [PAD_N-1:0][RES_W-1:0]             pad;
    logic [WORD_NUM-1:0][RES_W*OUT_BYTES-1:0] words;

    assign open_w   = wr_sel & ~full;
    assign cap      = open_w ? (result_valid & ~mask) : '0;
    assign nxt_mask = mask | cap;
    assign dup      = open_w & (|(result_valid & mask));
    // Captures of this cycle count toward completing or flushing the frame.
    assign close    = open_w & ((&nxt_mask) | (flush & (|nxt_mask)));

    always_comb begin
        if (full) begin
            state = FULL;
        end else if (|mask) begin
            state = FILLING;
        end else begin
            state = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '0;
            mask <= '0;
            full <= 1'b0;
        end else begin
            // free needs full=1 and captures need full=0, so they never overlap.
            if (free) begin
                full <= 1'b0;
                mem  <= '0;
            end else if (close) begin
                full <= 1'b1;
            end
            for (int k = 0; k < LANE_NUM; k++) begin
                if (cap[k]) begin
                    mem[k] <= result[RES_W*k +: RES_W];
                end
            end
            mask <= close ? '0 : nxt_mask;
        end
    end

    // Bytes past the last lane read as zero.
    always_comb begin
        pad = '0;
        for (int k = 0; k < LANE_NUM; k++) begin
            pad[k] = mem[k];
        end
    end

    assign words   = pad;
    assign rd_data = words[rd_word];

endmodule

// File: rtl/pe_result_collector.sv
// Collects lane-staggered pe_cube results into frames, double-buffers them
// and drains each frame as packed words over a valid/ready stream.
// Optional: RESULT_COLLECTOR_FRAME_TAG_EN adds oFrameTag (per-frame tag).
// Ports:
//   iClk, iRstN          clock, async active-low reset
//   iResult              per-lane bytes, lane k at [8k+7:8k]
//   iResultValid         per-lane capture strobes
//   iFlush               close the current partial frame
//   iClearOverflow       clear the sticky overflow flag
//   oData/oValid/iReady  packed output word stream
//   oLast                final word of a frame
//   oOverflow            sticky: a result was dropped
//   oBusy                a bank is full or the write bank is filling
//   oFrameTag            tag of the frame being drained (optional)
module pe_result_collector
    import pe_cube_pkg::*;
#(
    parameter  int ARRAY_NUM = 3,
    parameter  int BLOCK_NUM = 3,
    parameter  int CUBE_NUM  = 3,
    parameter  int OUT_BYTES = 4,
    localparam int LANE_NUM  = ARRAY_NUM * BLOCK_NUM * CUBE_NUM,
    localparam int WORD_NUM  = ceil_div(LANE_NUM, OUT_BYTES)
) (
    input  logic                        iClk,
    input  logic                        iRstN,
    input  logic [RES_W*LANE_NUM-1:0]   iResult,
    input  logic [LANE_NUM-1:0]         iResultValid,
    input  logic                        iFlush,
    input  logic                        iClearOverflow,
    output logic [RES_W*OUT_BYTES-1:0]  oData,
    output logic                        oValid,
    input  logic                        iReady,
    output logic                        oLast,
    output logic                        oOverflow,
    output logic                        oBusy
`ifdef RESULT_COLLECTOR_FRAME_TAG_EN
    ,
    output logic [7:0]                  oFrameTag
`endif
);

    localparam int WCNT_W = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORD_NUM - 1);

    logic                        wsel;
    logic                        rsel;
    logic [WCNT_W-1:0]           wcnt;
    logic                        overflow;
    logic [1:0]                  full;
    logic [1:0]                  close;
    logic [1:0]                  dup;
    logic [1:0]                  free;
    bank_state_e                 state [2];
    logic [RES_W*OUT_BYTES-1:0]  rd_data [2];
    logic                        fire;
    logic                        last_word;
    logic                        drop;

    assign fire      = oValid & iReady;
    assign last_word = (wcnt == LAST_WORD);
    // With the write bank full every valid is lost; otherwise only repeats.
    assign drop      = full[wsel] ? (|iResultValid) : (|dup);

    for (genvar i = 0; i < 2; i++) begin : g_bank
        assign free[i] = fire & last_word & (rsel == 1'(i));

        pe_result_bank #(
            .LANE_NUM  (LANE_NUM),
            .OUT_BYTES (OUT_BYTES),
            .WORD_NUM  (WORD_NUM),
            .WCNT_W    (WCNT_W)
        ) u_bank (
            .clk          (iClk),
            .rst_n        (iRstN),
            .wr_sel       (wsel == 1'(i)),
            .flush        (iFlush),
            .free         (free[i]),
            .result       (iResult),
            .result_valid (iResultValid),
            .rd_word      (wcnt),
            .full         (full[i]),
            .close        (close[i]),
            .dup          (dup[i]),
            .state        (state[i]),
            .rd_data      (rd_data[i])
        );
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            wsel     <= 1'b0;
            rsel     <= 1'b0;
            wcnt     <= '0;
            overflow <= 1'b0;
        end else begin
            if (|close) begin
                wsel <= ~wsel;
            end
            if (fire) begin
                if (last_word) begin
                    wcnt <= '0;
                    rsel <= ~rsel;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (iClearOverflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign oValid    = full[rsel];
    assign oLast     = oValid & last_word;
    assign oData     = oValid ? rd_data[rsel] : '0;
    assign oOverflow = overflow;
    assign oBusy     = (|full) | (state[wsel] == FILLING);

`ifdef RESULT_COLLECTOR_FRAME_TAG_EN
    logic [7:0] tag_cnt;
    logic [7:0] tag [2];

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            tag_cnt <= 8'd0;
            tag[0]  <= 8'd0;
            tag[1]  <= 8'd0;
        end else if (|close) begin
            tag[wsel] <= tag_cnt;
            tag_cnt   <= tag_cnt + 8'd1;
        end
    end

    assign oFrameTag = oValid ? tag[rsel] : 8'd0;
`endif

endmodule

// File: tb/tb_pe_result_collector.sv
// Directed bench for pe_result_collector: burst, skewed fill, ping-pong
// back-pressure, flush, reset mid-drain and (optionally) frame tags.
module tb_pe_result_collector;

    localparam int LANES = 27;
    localparam int WORDS = 7;

    logic              iClk = 1'b0;
    logic              iRstN = 1'b0;
    logic [8*LANES-1:0] iResult = '0;
    logic [LANES-1:0]  iResultValid = '0;
    logic              iFlush = 1'b0;
    logic              iClearOverflow = 1'b0;
    logic [31:0]       oData;
    logic              oValid;
    logic              iReady = 1'b0;
    logic              oLast;
    logic              oOverflow;
    logic              oBusy;
`ifdef RESULT_COLLECTOR_FRAME_TAG_EN
    logic [7:0]        oFrameTag;
`endif

    int errors = 0;
    int checks = 0;

    always #5 iClk = ~iClk;

    pe_result_collector dut (
        .iClk           (iClk),
        .iRstN          (iRstN),
        .iResult        (iResult),
        .iResultValid   (iResultValid),
        .iFlush         (iFlush),
        .iClearOverflow (iClearOverflow),
        .oData          (oData),
        .oValid         (oValid),
        .iReady         (iReady),
        .oLast          (oLast),
        .oOverflow      (oOverflow),
        .oBusy          (oBusy)
`ifdef RESULT_COLLECTOR_FRAME_TAG_EN
        ,
        .oFrameTag      (oFrameTag)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    task automatic load(input logic [7:0] base);
        for (int k = 0; k < LANES; k++) begin
            iResult[8*k +: 8] = base + 8'(k);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [7:0] base,
                                              input int w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            if (4*w + b < LANES) begin
                r[8*b +: 8] = base + 8'(4*w + b);
            end
        end
        return r;
    endfunction

    // Expects a frame of base+lane bytes to be presented now; iReady must be 1.
    task automatic drain_chk(input string name, input logic [7:0] base);
        for (int w = 0; w < WORDS; w++) begin
            chk($sformatf("%s valid w%0d", name, w), 32'(oValid), 32'd1);
            chk($sformatf("%s data w%0d", name, w), oData, exp_word(base, w));
            chk($sformatf("%s last w%0d", name, w), 32'(oLast),
                32'(w == WORDS-1));
            tick();
        end
    endtask

    logic [31:0] flush_exp [WORDS];

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst valid", 32'(oValid), 32'd0);
        chk("rst last", 32'(oLast), 32'd0);
        chk("rst data", oData, 32'd0);
        chk("rst ovf", 32'(oOverflow), 32'd0);
        chk("rst busy", 32'(oBusy), 32'd0);
        iRstN = 1'b1;
        tick();

        // Full burst: all lanes in one cycle, lane k = k+1
        iReady = 1'b1;
        load(8'd1);
        iResultValid = '1;
        chk("burst pre valid", 32'(oValid), 32'd0);
        tick();
        iResultValid = '0;
        chk("burst w0 const", oData, 32'h04030201);
        drain_chk("burst", 8'd1);
        chk("burst idle", 32'(oValid), 32'd0);
        chk("burst busy", 32'(oBusy), 32'd0);

        // Skewed fill, lane 3 repeated with a different byte
        iReady = 1'b0;
        for (int i = 0; i < LANES + 1; i++) begin
            int lane;
            lane = (i <= 3) ? i : i - 1;
            iResult = '0;
            iResult[8*lane +: 8] = (i == 4) ? 8'hEE : 8'h40 + 8'(lane);
            iResultValid = '0;
            iResultValid[lane] = 1'b1;
            if (i == 4) chk("skew ovf before", 32'(oOverflow), 32'd0);
            if (i == LANES) begin
                chk("skew not ready", 32'(oValid), 32'd0);
                chk("skew busy", 32'(oBusy), 32'd1);
            end
            tick();
            if (i == 4) chk("skew ovf after", 32'(oOverflow), 32'd1);
        end
        iResultValid = '0;
        iReady = 1'b1;
        chk("skew w0 const", oData, 32'h43424140);
        drain_chk("skew", 8'h40);
        chk("skew idle", 32'(oValid), 32'd0);
        iClearOverflow = 1'b1;
        tick();
        iClearOverflow = 1'b0;
        chk("ovf cleared", 32'(oOverflow), 32'd0);

        // Back-pressure and ping-pong
        iReady = 1'b0;
        load(8'd1);
        iResultValid = '1;
        tick();
        load(8'h80);
        tick();
        chk("pp valid", 32'(oValid), 32'd1);
        chk("pp busy", 32'(oBusy), 32'd1);
        load(8'hC0);
        iClearOverflow = 1'b1;
        tick();
        iResultValid = '0;
        iClearOverflow = 1'b0;
        chk("pp drop ovf", 32'(oOverflow), 32'd1);
        chk("pp hold data", oData, exp_word(8'd1, 0));
        tick();
        chk("pp hold data2", oData, exp_word(8'd1, 0));
        chk("pp hold last", 32'(oLast), 32'd0);
        chk("pp hold valid", 32'(oValid), 32'd1);
        iReady = 1'b1;
        drain_chk("ppA", 8'd1);
        drain_chk("ppB", 8'h80);
        chk("pp idle", 32'(oValid), 32'd0);
        chk("pp ovf sticky", 32'(oOverflow), 32'd1);
        iClearOverflow = 1'b1;
        tick();
        iClearOverflow = 1'b0;

        // Flush with empty mask does nothing
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
        tick();
        chk("flush empty valid", 32'(oValid), 32'd0);
        chk("flush empty busy", 32'(oBusy), 32'd0);

        // Partial frame: lanes 0-4 = 0xAA, then flush
        iReady = 1'b0;
        iResult = '1;
        for (int k = 0; k < LANES; k++) iResult[8*k +: 8] = 8'hAA;
        iResultValid = 27'h1F;
        tick();
        iResultValid = '0;
        chk("flush fill valid", 32'(oValid), 32'd0);
        chk("flush fill busy", 32'(oBusy), 32'd1);
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
        chk("flush valid", 32'(oValid), 32'd1);
        flush_exp[0] = 32'hAAAAAAAA;
        flush_exp[1] = 32'h000000AA;
        for (int w = 2; w < WORDS; w++) flush_exp[w] = 32'd0;
        iReady = 1'b1;
        for (int w = 0; w < WORDS; w++) begin
            chk($sformatf("flush data w%0d", w), oData, flush_exp[w]);
            chk($sformatf("flush last w%0d", w), 32'(oLast), 32'(w == WORDS-1));
            tick();
        end
        chk("flush idle", 32'(oValid), 32'd0);

        // Reset mid-drain
        load(8'h10);
        iResultValid = '1;
        tick();
        iResultValid = '0;
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("mid data w%0d", w), oData, exp_word(8'h10, w));
            tick();
        end
        iRstN = 1'b0;
        #1;
        chk("mid rst valid", 32'(oValid), 32'd0);
        chk("mid rst data", oData, 32'd0);
        chk("mid rst busy", 32'(oBusy), 32'd0);
        tick();
        iRstN = 1'b1;
        tick();
        chk("post rst valid", 32'(oValid), 32'd0);
        load(8'h30);
        iResultValid = '1;
        tick();
        iResultValid = '0;
        drain_chk("post", 8'h30);

`ifdef RESULT_COLLECTOR_FRAME_TAG_EN
        iRstN = 1'b0;
        tick();
        iRstN = 1'b1;
        tick();
        iReady = 1'b1;
        for (int f = 0; f < 257; f++) begin
            load(8'(f));
            iResultValid = '1;
            tick();
            iResultValid = '0;
            chk($sformatf("tag f%0d", f), 32'(oFrameTag), 32'(f % 256));
            repeat (WORDS) tick();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
